// File: rtl/slide_pot_rr_if.sv
// Pin bundle between the slide-pot reader, the SPI A2D and the equalizer
// datapath. The master side belongs to the reader; the slave side is the
// view from the A2D and the band scalers / volume stage.
interface slide_pot_rr_if;
    logic        MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [11:0] POT_LP;
    logic [11:0] POT_B1;
    logic [11:0] POT_B2;
    logic [11:0] POT_B3;
    logic [11:0] POT_HP;
    logic [11:0] VOLUME;
    logic        round_done;

    modport master (
        input  MISO,
        output SS_n,
        output SCLK,
        output MOSI,
        output POT_LP,
        output POT_B1,
        output POT_B2,
        output POT_B3,
        output POT_HP,
        output VOLUME,
        output round_done
    );

    modport slave (
        output MISO,
        input  SS_n,
        input  SCLK,
        input  MOSI,
        input  POT_LP,
        input  POT_B1,
        input  POT_B2,
        input  POT_B3,
        input  POT_HP,
        input  VOLUME,
        input  round_done
    );
endinterface

// File: rtl/slide_pot_rr.sv
// Round-robin reader for the six equalizer slide pots. Acts as SPI master to
// an 8-channel 12-bit A2D: per pot, one transaction selects the mux channel
// (its reply is dropped) and a second one fetches the conversion, which is
// latched into that pot's output register. Runs free from reset.
module slide_pot_rr #(
    parameter int unsigned IDLE_GAP = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    slide_pot_rr_if.master bus
);

    localparam int unsigned      GAP_W      = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(IDLE_GAP - 1);
    localparam logic [4:0]       DIV_PRESET = 5'b10111;
    localparam logic [4:0]       FALL_FINAL = 5'd16;
    localparam logic [2:0]       SLOT_LAST  = 3'd5;

    typedef enum logic [1:0] {
        S_GAP  = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [4:0]       r_div;
    logic [4:0]       r_fall_cnt;
    logic [15:0]      r_shreg;
    logic             r_miso_q;
    logic             r_phase_b;
    logic [2:0]       r_slot;
    logic             r_ss_n;
    logic             r_round_done;
    logic [11:0]      r_pot_lp;
    logic [11:0]      r_pot_b1;
    logic [11:0]      r_pot_b2;
    logic [11:0]      r_pot_b3;
    logic [11:0]      r_pot_hp;
    logic [11:0]      r_volume;

    logic             w_gap_done;
    logic             w_start;
    logic             w_fall;
    logic             w_rise;
    logic             w_shift;
    logic             w_xfer_end;
    logic [2:0]       w_ch;
    logic [15:0]      w_cmd;
    logic [15:0]      w_rx;

    assign w_gap_done = (r_gap_cnt == GAP_LAST);
    assign w_start    = (r_state != S_XFER) && (w_state_nxt == S_XFER);
    // div == 31 / 15 just before the edge means SCLK drops / rises on it
    assign w_fall     = (r_state == S_XFER) && (r_div == 5'b11111);
    assign w_rise     = (r_state == S_XFER) && (r_div == 5'b01111);
    // The first fall precedes any capture, so it does not shift
    assign w_shift    = w_fall && (r_fall_cnt != 5'd0);
    // The 17th fall point (offset 520) closes the transaction instead of
    // driving SCLK low; it still performs the final shift
    assign w_xfer_end = w_fall && (r_fall_cnt == FALL_FINAL);
    assign w_rx       = {r_shreg[14:0], r_miso_q};
    assign w_cmd      = {2'b00, w_ch, 11'h000};

    // Slot-to-A2D-channel map: pots are wired to channels 1,0,4,2,3,7
    always_comb begin
        w_ch = 3'd1;
        case (r_slot)
            3'd0:    w_ch = 3'd1;
            3'd1:    w_ch = 3'd0;
            3'd2:    w_ch = 3'd4;
            3'd3:    w_ch = 3'd2;
            3'd4:    w_ch = 3'd3;
            3'd5:    w_ch = 3'd7;
            default: w_ch = 3'd1;
        endcase
    end

    // Controller next-state: idle gap, transfer, one bookkeeping cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_GAP:   if (w_gap_done) w_state_nxt = S_XFER;
            S_XFER:  if (w_xfer_end) w_state_nxt = S_DONE;
            // DONE is already the first idle cycle of the gap, so a gap of
            // one cycle goes straight back to XFER
            S_DONE:  w_state_nxt = w_gap_done ? S_XFER : S_GAP;
            default: w_state_nxt = S_GAP;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_GAP;
        else        r_state <= w_state_nxt;
    end

    // Idle counter: counts SS_n-high cycles (DONE included), cleared in XFER
    always_ff @(posedge clk) begin
        if (!rst_n)                               r_gap_cnt <= '0;
        else if (r_state == S_XFER || w_gap_done) r_gap_cnt <= '0;
        else                                      r_gap_cnt <= r_gap_cnt + 1'b1;
    end

    // Chip select, registered so it never glitches
    always_ff @(posedge clk) begin
        if (!rst_n) r_ss_n <= 1'b1;
        else        r_ss_n <= (w_state_nxt != S_XFER);
    end

    // SCLK divider: parked at the preset while idle and stepping from the
    // SS_n fall edge itself, which puts the first SCLK fall at offset 8
    always_ff @(posedge clk) begin
        if (!rst_n)                                     r_div <= DIV_PRESET;
        else if (w_start || (r_state == S_XFER && !w_xfer_end)) r_div <= r_div + 5'd1;
        else                                            r_div <= DIV_PRESET;
    end

    // Counts SCLK fall points within a transaction
    always_ff @(posedge clk) begin
        if (!rst_n)      r_fall_cnt <= '0;
        else if (w_start) r_fall_cnt <= '0;
        else if (w_fall)  r_fall_cnt <= r_fall_cnt + 5'd1;
    end

    // Capture MISO on each SCLK rise
    always_ff @(posedge clk) begin
        if (!rst_n)     r_miso_q <= 1'b0;
        else if (w_rise) r_miso_q <= bus.MISO;
    end

    // Shift register: command out MSB first, reply shifted in behind it
    always_ff @(posedge clk) begin
        if (!rst_n)       r_shreg <= '0;
        else if (w_start) r_shreg <= w_cmd;
        else if (w_shift) r_shreg <= w_rx;
    end

    // A/B phase toggle and slot advance, once per transaction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase_b <= 1'b0;
            r_slot    <= '0;
        end else if (r_state == S_DONE) begin
            r_phase_b <= ~r_phase_b;
            if (r_phase_b) r_slot <= (r_slot == SLOT_LAST) ? 3'd0 : r_slot + 3'd1;
        end
    end

    // Latch the conversion of transaction B into its slot's pot register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pot_lp <= '0;
            r_pot_b1 <= '0;
            r_pot_b2 <= '0;
            r_pot_b3 <= '0;
            r_pot_hp <= '0;
            r_volume <= '0;
        end else if (w_xfer_end && r_phase_b) begin
            case (r_slot)
                3'd0:    r_pot_lp <= w_rx[11:0];
                3'd1:    r_pot_b1 <= w_rx[11:0];
                3'd2:    r_pot_b2 <= w_rx[11:0];
                3'd3:    r_pot_b3 <= w_rx[11:0];
                3'd4:    r_pot_hp <= w_rx[11:0];
                3'd5:    r_volume <= w_rx[11:0];
                default: ;
            endcase
        end
    end

    // Pass marker: high for the DONE cycle following the VOLUME write
    always_ff @(posedge clk) begin
        if (!rst_n) r_round_done <= 1'b0;
        else        r_round_done <= w_xfer_end && r_phase_b && (r_slot == SLOT_LAST);
    end

    assign bus.SS_n       = r_ss_n;
    assign bus.SCLK       = r_div[4];
    assign bus.MOSI       = r_shreg[15];
    assign bus.POT_LP     = r_pot_lp;
    assign bus.POT_B1     = r_pot_b1;
    assign bus.POT_B2     = r_pot_b2;
    assign bus.POT_B3     = r_pot_b3;
    assign bus.POT_HP     = r_pot_hp;
    assign bus.VOLUME     = r_volume;
    assign bus.round_done = r_round_done;

endmodule

// File: tb/tb_slide_pot_rr.sv
// Bench for slide_pot_rr: an A2D model answers each transaction from a
// per-transaction reply table and logs commands and edge times; directed
// vector records give replies and expected pot values per pass.
module tb_slide_pot_rr;

    localparam int unsigned IDLE_GAP = 32;
    localparam int TXN_LEN    = 520;
    localparam int TXN_PERIOD = 552;
    localparam int PASS_LEN   = 6624;

    typedef struct packed {
        logic [15:0]      cmd;
        logic [2:0][15:0] rx_b;
        logic [2:0][11:0] pot;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   ecount   = 0;

    vec_t tbl [6];

    slide_pot_rr_if bus ();

    slide_pot_rr #(.IDLE_GAP(IDLE_GAP)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecount <= rst_n ? ecount + 1 : 0;

    logic [15:0] resp_w  [64];
    logic [15:0] cmd_log [64];
    int          fall_t  [64];
    int          rise_t  [64];
    int          fall_off [16];
    int          rise_off [16];
    int          rd_t    [8];
    int          txn = 0, rise_cnt = 0, nf0 = 0, nr0 = 0, nrd = 0;
    int          idle_edges = 0, rst_edges = 0, b2_first_t = -1;
    logic [11:0] b2_first_v = '0;
    logic [15:0] word = '0, cmd_sh = '0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b1, saw777 = 1'b0;

    // A2D model and bus monitor
    always @(negedge clk) begin
        prev_ss   <= bus.SS_n;
        prev_sclk <= bus.SCLK;
        if (bus.POT_LP === 12'h777 || bus.POT_B1 === 12'h777 || bus.POT_B2 === 12'h777 ||
            bus.POT_B3 === 12'h777 || bus.POT_HP === 12'h777 || bus.VOLUME === 12'h777)
            saw777 <= 1'b1;
        if (!rst_n) begin
            txn <= 0; nrd <= 0; nf0 <= 0; nr0 <= 0; idle_edges <= 0;
            b2_first_t <= -1; bus.MISO <= 1'b0; rise_cnt <= 0; cmd_sh <= '0;
            if (bus.SCLK !== prev_sclk) rst_edges <= rst_edges + 1;
        end else begin
            if (prev_ss && !bus.SS_n) begin
                word     <= resp_w[txn % 64];
                bus.MISO <= resp_w[txn % 64][15];
                rise_cnt <= 0;
                cmd_sh   <= '0;
                fall_t[txn % 64] <= ecount;
            end else if (!prev_ss && bus.SS_n) begin
                cmd_log[txn % 64] <= cmd_sh;
                rise_t[txn % 64]  <= ecount;
                txn <= txn + 1;
            end else if (!bus.SS_n) begin
                if (!prev_sclk && bus.SCLK) begin
                    cmd_sh   <= {cmd_sh[14:0], bus.MOSI};
                    rise_cnt <= rise_cnt + 1;
                    if (txn == 0 && nr0 < 16) begin
                        rise_off[nr0] <= ecount - fall_t[0];
                        nr0 <= nr0 + 1;
                    end
                end else if (prev_sclk && !bus.SCLK) begin
                    if (rise_cnt > 0 && rise_cnt < 16) bus.MISO <= word[15 - rise_cnt];
                    if (txn == 0 && nf0 < 16) begin
                        fall_off[nf0] <= ecount - fall_t[0];
                        nf0 <= nf0 + 1;
                    end
                end
            end else if (bus.SCLK !== prev_sclk) begin
                idle_edges <= idle_edges + 1;
            end
            if (bus.round_done === 1'b1) begin
                if (nrd < 8) rd_t[nrd] <= ecount;
                nrd <= nrd + 1;
            end
            if (b2_first_t < 0 && bus.POT_B2 !== 12'h000) begin
                b2_first_t <= ecount;
                b2_first_v <= bus.POT_B2;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pot_of(input int s);
        case (s)
            0:       return bus.POT_LP;
            1:       return bus.POT_B1;
            2:       return bus.POT_B2;
            3:       return bus.POT_B3;
            4:       return bus.POT_HP;
            default: return bus.VOLUME;
        endcase
    endfunction

    initial begin
        int guard;
        // slot order: ch1, ch0, ch4, ch2, ch3, ch7; rx_b/pot listed {pass2, pass1, pass0}
        tbl[0] = '{cmd:16'h0800, rx_b:{16'h5A5A, 16'h0111, 16'hFABC}, pot:{12'hA5A, 12'h111, 12'hABC}};
        tbl[1] = '{cmd:16'h0000, rx_b:{16'h1001, 16'hF456, 16'h0123}, pot:{12'h001, 12'h456, 12'h123}};
        tbl[2] = '{cmd:16'h2000, rx_b:{16'h7FFE, 16'h0001, 16'h0FFF}, pot:{12'hFFE, 12'h001, 12'hFFF}};
        tbl[3] = '{cmd:16'h1000, rx_b:{16'h8800, 16'h0ABC, 16'h0000}, pot:{12'h800, 12'hABC, 12'h000}};
        tbl[4] = '{cmd:16'h1800, rx_b:{16'h0F0F, 16'h3333, 16'h0800}, pot:{12'hF0F, 12'h333, 12'h800}};
        tbl[5] = '{cmd:16'h3800, rx_b:{16'h0FEE, 16'h0AAA, 16'h0555}, pot:{12'hFEE, 12'hAAA, 12'h555}};
        // every A transaction answers 0777, which must never reach a pot
        for (int i = 0; i < 64; i++)
            resp_w[i] = (i % 2 == 0) ? 16'h0777 : tbl[(i / 2) % 6].rx_b[(i / 12) % 3];

        // reset held for 5 cycles
        rst_n = 1'b0;
        step(5);
        chk("rst_ss_n", 32'(bus.SS_n), 32'd1);
        chk("rst_sclk", 32'(bus.SCLK), 32'd1);
        chk("rst_mosi", 32'(bus.MOSI), 32'd0);
        chk("rst_round_done", 32'(bus.round_done), 32'd0);
        for (int s = 0; s < 6; s++) chk($sformatf("rst_pot%0d", s), 32'(pot_of(s)), 32'd0);
        chk("rst_sclk_edges", 32'(rst_edges), 32'd0);

        // three passes
        rst_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            guard = 0;
            while (nrd < p + 1 && guard < PASS_LEN + 2000) begin
                step(1);
                guard++;
            end
            chk($sformatf("rd_count_p%0d", p), 32'(nrd), 32'(p + 1));
            chk($sformatf("rd_time_p%0d", p), 32'(rd_t[p]), 32'(PASS_LEN * (p + 1)));
            for (int s = 0; s < 6; s++)
                chk($sformatf("pot_p%0d_s%0d", p, s), 32'(pot_of(s)), 32'(tbl[s].pot[p]));
            if (p == 0) begin
                chk("first_fall", 32'(fall_t[0]), 32'(IDLE_GAP));
                chk("first_len", 32'(rise_t[0] - fall_t[0]), 32'(TXN_LEN));
                chk("sclk_falls", 32'(nf0), 32'd16);
                chk("sclk_rises", 32'(nr0), 32'd16);
                for (int k = 0; k < 16; k++) begin
                    chk($sformatf("sclk_fall%0d", k), 32'(fall_off[k]), 32'(8 + 32 * k));
                    chk($sformatf("sclk_rise%0d", k), 32'(rise_off[k]), 32'(24 + 32 * k));
                end
            end
        end
        step(3);
        chk("rd_total", 32'(nrd), 32'd3);
        for (int i = 0; i < 36; i++) begin
            chk($sformatf("cmd%0d", i), 32'(cmd_log[i]), 32'(tbl[(i / 2) % 6].cmd));
            chk($sformatf("fall_t%0d", i), 32'(fall_t[i]), 32'(IDLE_GAP + TXN_PERIOD * i));
        end
        chk("idle_sclk_edges", 32'(idle_edges), 32'd0);
        chk("a_data_hidden", 32'(saw777), 32'd0);

        // reset at offset 300 of transaction B for ch4 (transaction 41)
        guard = 0;
        while (!(txn == 41 && bus.SS_n === 1'b0) && guard < 4000) begin
            step(1);
            guard++;
        end
        chk("mid_reach_txn", 32'(txn), 32'd41);
        guard = 0;
        while (ecount - fall_t[41] < 300 && guard < 600) begin
            step(1);
            guard++;
        end
        rst_n = 1'b0;
        step(1);
        chk("mid_ss_n", 32'(bus.SS_n), 32'd1);
        chk("mid_sclk", 32'(bus.SCLK), 32'd1);
        chk("mid_round_done", 32'(bus.round_done), 32'd0);
        for (int s = 0; s < 6; s++) chk($sformatf("mid_pot%0d", s), 32'(pot_of(s)), 32'd0);
        step(2);
        rst_n = 1'b1;
        guard = 0;
        while (txn < 6 && guard < 4000) begin
            step(1);
            guard++;
        end
        chk("post_txn_count", 32'(txn), 32'd6);
        chk("post_cmd0", 32'(cmd_log[0]), 32'h0800);
        chk("post_fall0", 32'(fall_t[0]), 32'(IDLE_GAP));
        chk("post_b2_time", 32'(b2_first_t), 32'(IDLE_GAP + TXN_PERIOD * 5 + TXN_LEN));
        chk("post_b2_value", 32'(b2_first_v), 32'h0FFF);
        chk("post_pot_lp", 32'(bus.POT_LP), 32'h0ABC);
        chk("post_a_data_hidden", 32'(saw777), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
